// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : controller states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : default operand/result width
package subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: computes a - b - bin.
// Ports:
//   a, b  : operand bits (minuend, subtrahend)
//   bin   : borrow in
//   diff  : difference bit
//   bout  : borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    // Borrow when a < b, or when a == b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: d = n1 - n2, one bit per clock,
// LSB first, through a single full_subtractor cell.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   start          : operation request, sampled only while idle
//   n1, n2         : minuend and subtrahend, captured when start is accepted
//   busy           : high while bits are being processed
//   done           : one-cycle pulse after the result is loaded
//   d              : difference (updated only at completion)
//   Bo             : unsigned borrow out (n1 < n2 unsigned)
//   Overflow       : signed overflow (borrow into MSB xor borrow out of MSB)
module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n1,
    input  logic [WIDTH-1:0] n2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             Bo,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] r_reg;
    logic             br_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] d_reg;
    logic             bo_reg;
    logic             ovf_reg;

    logic             cell_diff;
    logic             cell_bout;
    logic [WIDTH-1:0] r_next;

    full_subtractor u_cell (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (br_reg),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // New difference bit enters at the MSB; after WIDTH shifts the LSB of
    // the result has reached bit 0. On the last bit this is the final result.
    assign r_next = WIDTH'({cell_diff, r_reg} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            d_reg     <= '0;
            bo_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= n1;
                        b_reg     <= n2;
                        br_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    r_reg   <= r_next;
                    br_reg  <= cell_bout;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        d_reg     <= r_next;
                        bo_reg    <= cell_bout;
                        // br_reg still holds the borrow into the MSB here.
                        ovf_reg   <= br_reg ^ cell_bout;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_reg == SHIFT);
    assign done     = (state_reg == DONE);
    assign d        = d_reg;
    assign Bo       = bo_reg;
    assign Overflow = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): directed vectors with
// hand-computed results, reset/abort, ignored start during SHIFT, operand
// changes after acceptance, and back-to-back operation with start held high.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] n1;
    logic [W-1:0] n2;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bo;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] n1;
        logic [W-1:0] n2;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Directed vectors: n1, n2 -> d, Bo, Overflow (computed by hand).
    logic [W-1:0] va  [5];
    logic [W-1:0] vb  [5];
    logic [W-1:0] vd  [5];
    logic         vbo [5];
    logic         vov [5];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n1       (n1),
        .n2       (n2),
        .busy     (busy),
        .done     (done),
        .d        (d),
        .Bo       (bo),
        .Overflow (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (done) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got d=%h Bo=%0b Ov=%0b, required no done pulse",
                             d, bo, ovf);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("[TB] op n1=%h n2=%h -> d=%h Bo=%0b Ov=%0b (exp d=%h Bo=%0b Ov=%0b)",
                             e.n1, e.n2, d, bo, ovf, e.d, e.bo, e.ov);
                    chk("result_d", {28'd0, d}, {28'd0, e.d});
                    chk("result_bo", {31'd0, bo}, {31'd0, e.bo});
                    chk("result_ov", {31'd0, ovf}, {31'd0, e.ov});
                end
            end
        end
    end

    // Single operation with mid-flight disturbances: operands scrambled right
    // after acceptance and a start pulse with different operands during SHIFT.
    task automatic run_op(input int i);
        exp_t e;
        int   busy_cnt;
        int   done_at;
        bit   got;
        busy_cnt = 0;
        done_at  = 0;
        got      = 1'b0;
        @(negedge clk);
        n1    = va[i];
        n2    = vb[i];
        start = 1'b1;
        e     = '{n1: va[i], n2: vb[i], d: vd[i], bo: vbo[i], ov: vov[i]};
        sb_q.push_back(e);
        @(negedge clk);                  // edge E0 has passed
        for (int k = 1; k <= 20 && !got; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                got     = 1'b1;
                done_at = k;
            end
            if (k == 1) begin
                start = 1'b0;
                n1    = ~va[i];
                n2    = ~vb[i];
            end
            if (k == 2) begin
                start = 1'b1;
                n1    = 4'h3;
                n2    = 4'h9;
            end
            if (k == 3) start = 1'b0;
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("latency", done_at, W + 1);
        chk("busy_cycles", busy_cnt, W);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
        chk("d_hold", {28'd0, d}, {28'd0, vd[i]});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int prev;
        int done_hits;

        va[0] = 4'h5; vb[0] = 4'h3; vd[0] = 4'h2; vbo[0] = 1'b0; vov[0] = 1'b0;
        va[1] = 4'h3; vb[1] = 4'h5; vd[1] = 4'hE; vbo[1] = 1'b1; vov[1] = 1'b0;
        va[2] = 4'h7; vb[2] = 4'hF; vd[2] = 4'h8; vbo[2] = 1'b1; vov[2] = 1'b1;
        va[3] = 4'h8; vb[3] = 4'h1; vd[3] = 4'h7; vbo[3] = 1'b0; vov[3] = 1'b1;
        va[4] = 4'hA; vb[4] = 4'hA; vd[4] = 4'h0; vbo[4] = 1'b0; vov[4] = 1'b0;

        rst   = 1'b1;
        start = 1'b0;
        n1    = '0;
        n2    = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_d", {28'd0, d}, 32'd0);
        chk("rst_bo", {31'd0, bo}, 32'd0);
        chk("rst_ov", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Abort: reset in the middle of SHIFT, no result and no done pulse.
        n1    = 4'h5;
        n2    = 4'h3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        rst       = 1'b0;
        done_hits = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_hits++;
        end
        chk("abort_no_done", done_hits, 0);
        chk("abort_d", {28'd0, d}, 32'd0);
        chk("abort_bo", {31'd0, bo}, 32'd0);

        for (int i = 0; i < 5; i++) run_op(i);

        // Back-to-back with start held high: one result every W+2 cycles.
        @(negedge clk);
        idx   = 0;
        prev  = -1;
        start = 1'b1;
        n1    = va[0];
        n2    = vb[0];
        sb_q.push_back('{n1: va[0], n2: vb[0], d: vd[0], bo: vbo[0], ov: vov[0]});
        for (int cyc = 1; cyc <= 40 && idx < 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (prev >= 0) chk("b2b_period", cyc - prev, W + 2);
                prev = cyc;
                idx++;
                if (idx < 3) begin
                    n1 = va[idx + 1];
                    n2 = vb[idx + 1];
                    sb_q.push_back('{n1: va[idx + 1], n2: vb[idx + 1], d: vd[idx + 1],
                                     bo: vbo[idx + 1], ov: vov[idx + 1]});
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_ops_completed", idx, 3);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `d = n1 - n2` over `WIDTH` clock cycles, one bit per cycle, LSB first, through a single full-subtractor cell. It is the subtraction counterpart of the team's combinational ripple adder and sits in the ALU datapath where area matters more than latency. A start/busy/done handshake frames each operation. Unsigned borrow and signed overflow flags are reported with the result.

## Interface
Parameters:
- `WIDTH`, 4, operand and result width in bits (≥ 2).

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Sampled only in IDLE.
- `n1`  in  WIDTH  minuend. Captured on the accepted start edge.
- `n2`  in  WIDTH  subtrahend. Captured on the accepted start edge.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse in DONE.
- `d`  out  WIDTH  difference. Updated only at completion.
- `Bo`  out  1  unsigned borrow out: high iff n1 < n2 as unsigned values.
- `Overflow`  out  1  signed overflow: borrow into MSB XOR borrow out of MSB.

## Operation
- FSM states:
  - IDLE:
    - `start=1` → SHIFT.
    - Latch n1 and n2 into shift registers `a` and `b`.
    - Clear the borrow flop `br` and the bit counter `cnt`.
  - SHIFT:
    - Each cycle, cell inputs are `a[0]`, `b[0]`, `br`.
    - Cell outputs:
      - `diff = a^b^br`
      - `bout = (~a&b) | (~(a^b)&br)`
    - `diff` shifts into the MSB of result shift register `r`.
    - `a` and `b` shift right. `br <= bout`. `cnt++`.
    - On the bit where `cnt = WIDTH-1`, also load the outputs:
      - `d <= {diff, r[WIDTH-1:1]}`
      - `Bo <= bout`
      - `Overflow <= br ^ bout` (current `br` is the borrow into the MSB)
    - Same edge → DONE.
  - DONE: `done=1` for exactly one cycle, then → IDLE unconditionally.
- `start` is ignored in SHIFT and DONE; no queuing.
- `n1`/`n2` may change freely after the accepted start edge.
- `d`, `Bo` and `Overflow` hold their last result until the next completion. They are never exposed mid-operation.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `d=0`, `Bo=0`, `Overflow=0`, `a=b=r=0`, `br=0`, `cnt=0`.
- `rst` asserted mid-operation aborts immediately. No result update and no `done` pulse.
- Edge E0 is the edge where `start=1` is sampled in IDLE. Then:
  - `busy` is high for cycles E0..E(WIDTH).
  - `d`, `Bo` and `Overflow` become valid at edge E(WIDTH).
  - `done` is high for the cycle following E(WIDTH), then falls at E(WIDTH+1).
- Latency: WIDTH+1 edges from start to the fall of `done`.
- Back-to-back: the earliest next accepted start is edge E(WIDTH+2), i.e. start held high throughout yields one operation every WIDTH+2 cycles.
- `busy` and `done` are never high together.

## Structure
- Package `subtractor_pkg`:
  - state enum `{IDLE, SHIFT, DONE}`.
  - `DEFAULT_WIDTH = 4`.
- Sub-module `full_subtractor`:
  - combinational, ports `a`, `b`, `bin`, `diff`, `bout`.
  - one instance.
- Counter width: `$clog2(WIDTH)`.
- Everything else in `serial_subtractor`.

## Test plan
- Reset then idle: all outputs 0, `busy=0`. Pulse `rst` mid-SHIFT → back to IDLE, outputs keep pre-reset values of 0, no `done`.
- Basic case, WIDTH=4: n1=5, n2=3, start → `busy` for 4 cycles, `done` pulse, d=2, Bo=0, Overflow=0.
- Unsigned borrow: n1=3, n2=5 → d=4'hE, Bo=1, Overflow=0.
- Signed overflow, positive: n1=4'h7, n2=4'hF → d=4'h8, Bo=1, Overflow=1.
- Signed overflow, negative: n1=4'h8, n2=4'h1 → d=4'h7, Bo=0, Overflow=1.
- Equal operands: n1=n2=4'hA → d=0, Bo=0, Overflow=0.
- Handshake:
  - `start` held high continuously → operations every 6 cycles.
  - `start` pulsed during SHIFT with new operands → ignored; result reflects the original operands.
  - `n1`/`n2` changed after E0 → no effect on the result.
